// File: rtl/nano_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nano_pkg
//  Purpose  : Shared widths, I/O window base, state and FIFO entry types for
//             the NanoCPU memory/output subsystem.
//  Revision : 1.0  initial release
// ============================================================================
package nano_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] IO_BASE = 8'hF0;

    typedef enum logic [0:0] {
        HOLD = 1'b0,
        RUN  = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [3:0]        addr;
        logic [DATA_W-1:0] data;
    } io_entry_t;

endpackage
`default_nettype wire

// File: rtl/nano_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : nano_out_fifo
//  Purpose  : Output FIFO of I/O window writes with saturating drop counter.
//  Revision : 1.0  initial release
// ============================================================================
module nano_out_fifo
    import nano_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      ck,
    input  logic      rst,
    input  logic      push,
    input  io_entry_t push_entry,
    input  logic      pop,
    output logic      valid,
    output io_entry_t head,
    output logic [7:0] drop_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);

    io_entry_t          r_mem [DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic [7:0]         r_drop_cnt;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;
    logic w_drop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_do_pop  = pop & ~w_empty;
    assign w_do_push = push & (~w_full | w_do_pop);
    assign w_drop    = push & w_full & ~w_do_pop;

    always_ff @(posedge ck) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge ck) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= push_entry;
    end

    assign valid    = ~w_empty;
    assign head     = w_empty ? '0 : r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: rtl/nano_mem_io.sv
`default_nettype none
// ============================================================================
//  Module   : nano_mem_io
//  Purpose  : Unified program/data memory with loader port, CPU reset hold
//             and an output FIFO fed by writes to the I/O window.
//  Revision : 1.0  initial release
// ============================================================================
module nano_mem_io
    import nano_pkg::*;
#(
    parameter int               DEPTH      = 256,
    parameter int               WIDTH      = 16,
    parameter logic [ADDR_W-1:0] IO_BASE   = nano_pkg::IO_BASE,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic              ck,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  dataW,
    input  logic              ce,
    input  logic              we,
    output logic [WIDTH-1:0]  dataR,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]  ld_data,
    input  logic              ld_done,
    output logic              cpu_rst,
    output logic              out_valid,
    output logic [3:0]        out_addr,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [7:0]        drop_cnt
);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    mem_state_t        r_state;
    mem_state_t        w_next_state;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [WIDTH-1:0]  w_mem_data;
    logic              w_push;
    io_entry_t         w_push_entry;
    io_entry_t         w_head;

    always_ff @(posedge ck) begin
        if (rst) r_state <= HOLD;
        else     r_state <= w_next_state;
    end

    // Single memory write port, muxed between loader (HOLD) and CPU (RUN).
    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_mem_addr   = ld_addr;
        w_mem_data   = ld_data;
        case (r_state)
            HOLD: begin
                w_mem_we = ld_we;
                if (ld_done) w_next_state = RUN;
            end
            RUN: begin
                w_mem_we   = ce & we;
                w_mem_addr = address;
                w_mem_data = dataW;
            end
            default: w_next_state = HOLD;
        endcase
    end

    // Memory is deliberately not reset so a program survives a CPU reset.
    always_ff @(posedge ck) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    end

    assign dataR   = r_mem[address];
    assign cpu_rst = (r_state == HOLD);

    assign w_push            = (r_state == RUN) & ce & we & (address >= IO_BASE);
    assign w_push_entry.addr = address[3:0];
    assign w_push_entry.data = dataW;

    nano_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .ck         (ck),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (out_ready),
        .valid      (out_valid),
        .head       (w_head),
        .drop_cnt   (drop_cnt)
    );

    assign out_addr = w_head.addr;
    assign out_data = w_head.data;

endmodule
`default_nettype wire

// File: tb/tb_nano_mem_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nano_mem_io
//  Purpose  : Self-checking bench: directed vector table, corner sequences and
//             random traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nano_mem_io;

    logic        ck = 1'b0;
    logic        rst;
    logic [7:0]  address;
    logic [15:0] dataW;
    logic        ce;
    logic        we;
    logic [15:0] dataR;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_done;
    logic        cpu_rst;
    logic        out_valid;
    logic [3:0]  out_addr;
    logic [15:0] out_data;
    logic        out_ready;
    logic [7:0]  drop_cnt;

    always #5 ck = ~ck;

    nano_mem_io dut (
        .ck        (ck),
        .rst       (rst),
        .address   (address),
        .dataW     (dataW),
        .ce        (ce),
        .we        (we),
        .dataR     (dataR),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .cpu_rst   (cpu_rst),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory with known-flags, a bounded queue, a counter.
    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    logic [15:0] m_mem   [256];
    bit          m_known [256];
    bit          m_hold = 1'b1;
    ent_t        m_q [$];
    int          m_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit   push;
        ent_t e;
        push = 1'b0;
        if (m_hold) begin
            if (ld_we) begin
                m_mem[ld_addr]   = ld_data;
                m_known[ld_addr] = 1'b1;
            end
        end else if (ce && we) begin
            m_mem[address]   = dataW;
            m_known[address] = 1'b1;
            push = (address >= 8'hF0);
        end
        if (rst) begin
            m_hold = 1'b1;
            m_q.delete();
            m_drop = 0;
        end else begin
            if (m_hold && ld_done) m_hold = 1'b0;
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < 4) begin
                    e.a = address[3:0];
                    e.d = dataW;
                    m_q.push_back(e);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge ck);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0]  ea;
        logic [15:0] ed;
        ea = 4'h0;
        ed = 16'h0000;
        if (m_q.size() > 0) begin
            ea = m_q[0].a;
            ed = m_q[0].d;
        end
        chk({tag, " cpu_rst"},   32'(cpu_rst),   32'(m_hold));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
        chk({tag, " out_addr"},  32'(out_addr),  32'(ea));
        chk({tag, " out_data"},  32'(out_data),  32'(ed));
        chk({tag, " drop_cnt"},  32'(drop_cnt),  32'(m_drop));
        if (m_known[address]) chk({tag, " dataR"}, 32'(dataR), 32'(m_mem[address]));
    endtask

    task automatic set_idle();
        rst       = 1'b0;
        ld_we     = 1'b0;
        ld_addr   = 8'h00;
        ld_data   = 16'h0000;
        ld_done   = 1'b0;
        ce        = 1'b0;
        we        = 1'b0;
        address   = 8'h00;
        dataW     = 16'h0000;
        out_ready = 1'b0;
    endtask

    task automatic wwrite(input logic [7:0] a, input logic [15:0] d, input logic rdy);
        set_idle();
        ce        = 1'b1;
        we        = 1'b1;
        address   = a;
        dataW     = d;
        out_ready = rdy;
        cycle();
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [3:0] a,
                            input logic [15:0] d, input logic [7:0] drop);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, " out_addr"},  32'(out_addr),  32'(a));
        chk({tag, " out_data"},  32'(out_data),  32'(d));
        chk({tag, " drop_cnt"},  32'(drop_cnt),  32'(drop));
    endtask

    typedef struct {
        logic        rst;
        logic        ld_we;
        logic [7:0]  ld_addr;
        logic [15:0] ld_data;
        logic        ld_done;
        logic        ce;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        ready;
        logic        e_cpu_rst;
        logic        e_valid;
        logic [3:0]  e_oaddr;
        logic [15:0] e_odata;
        logic [7:0]  e_drop;
        logic        e_chk_r;
        logic [15:0] e_dataR;
    } vec_t;

    vec_t tv [13];

    logic [3:0]  drain_a [4];
    logic [15:0] drain_d [4];
    logic        drain_v [4];

    initial begin
        set_idle();
        rst = 1'b1;

        // Inputs for one edge, then expected outputs just after that edge.
        tv[0]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0,
                   1'b1, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b0, 16'h0000};
        tv[1]  = '{1'b0, 1'b1, 8'h00, 16'h4000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0,
                   1'b1, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b1, 16'h4000};
        tv[2]  = '{1'b0, 1'b1, 8'h09, 16'h000A, 1'b0, 1'b0, 1'b0, 8'h09, 16'h0000, 1'b0,
                   1'b1, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b1, 16'h000A};
        tv[3]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h09, 16'hFFFF, 1'b0,
                   1'b1, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b1, 16'h000A};
        tv[4]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h09, 16'h0000, 1'b0,
                   1'b0, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b1, 16'h000A};
        tv[5]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h10, 16'h1234, 1'b0,
                   1'b0, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b1, 16'h1234};
        tv[6]  = '{1'b0, 1'b1, 8'h10, 16'hDEAD, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b0,
                   1'b0, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b1, 16'h1234};
        tv[7]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b0,
                   1'b0, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b1, 16'h1234};
        tv[8]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hF3, 16'h0001, 1'b0,
                   1'b0, 1'b1, 4'h3, 16'h0001, 8'd0, 1'b1, 16'h0001};
        tv[9]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hF7, 16'h0002, 1'b0,
                   1'b0, 1'b1, 4'h3, 16'h0001, 8'd0, 1'b1, 16'h0002};
        tv[10] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'hF3, 16'h0000, 1'b1,
                   1'b0, 1'b1, 4'h7, 16'h0002, 8'd0, 1'b1, 16'h0001};
        tv[11] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'hF7, 16'h0000, 1'b1,
                   1'b0, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b1, 16'h0002};
        tv[12] = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hF5, 16'h5555, 1'b0,
                   1'b1, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b1, 16'h5555};

        for (int i = 0; i < 13; i++) begin
            rst       = tv[i].rst;
            ld_we     = tv[i].ld_we;
            ld_addr   = tv[i].ld_addr;
            ld_data   = tv[i].ld_data;
            ld_done   = tv[i].ld_done;
            ce        = tv[i].ce;
            we        = tv[i].we;
            address   = tv[i].addr;
            dataW     = tv[i].wdata;
            out_ready = tv[i].ready;
            cycle();
            chk($sformatf("row%0d cpu_rst", i),   32'(cpu_rst),   32'(tv[i].e_cpu_rst));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tv[i].e_valid));
            chk($sformatf("row%0d out_addr", i),  32'(out_addr),  32'(tv[i].e_oaddr));
            chk($sformatf("row%0d out_data", i),  32'(out_data),  32'(tv[i].e_odata));
            chk($sformatf("row%0d drop_cnt", i),  32'(drop_cnt),  32'(tv[i].e_drop));
            if (tv[i].e_chk_r)
                chk($sformatf("row%0d dataR", i), 32'(dataR), 32'(tv[i].e_dataR));
        end

        // Overflow: six pushes into a 4-deep FIFO, then push+pop while full.
        set_idle();
        ld_done = 1'b1;
        cycle();
        check_model("enter_run");
        for (int i = 0; i < 6; i++) wwrite(8'(8'hF0 + i), 16'(16'h0100 + i), 1'b0);
        chk_head("after6", 1'b1, 4'h0, 16'h0100, 8'd2);
        wwrite(8'hF6, 16'h0106, 1'b1);
        chk_head("full_push_pop", 1'b1, 4'h1, 16'h0101, 8'd2);
        drain_a[0] = 4'h2; drain_d[0] = 16'h0102; drain_v[0] = 1'b1;
        drain_a[1] = 4'h3; drain_d[1] = 16'h0103; drain_v[1] = 1'b1;
        drain_a[2] = 4'h6; drain_d[2] = 16'h0106; drain_v[2] = 1'b1;
        drain_a[3] = 4'h0; drain_d[3] = 16'h0000; drain_v[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_idle();
            out_ready = 1'b1;
            cycle();
            chk_head($sformatf("drain%0d", k), drain_v[k], drain_a[k], drain_d[k], 8'd2);
        end

        for (int i = 0; i < 300; i++) wwrite(8'hF8, 16'(i), 1'b0);
        chk_head("saturate", 1'b1, 4'h8, 16'h0000, 8'd255);

        // Reset with three entries pending; memory must keep its contents.
        set_idle();
        rst = 1'b1;
        cycle();
        chk_head("rst_clear", 1'b0, 4'h0, 16'h0000, 8'd0);
        chk("rst_clear cpu_rst", 32'(cpu_rst), 32'd1);
        set_idle();
        ld_done = 1'b1;
        cycle();
        wwrite(8'hFA, 16'hAAAA, 1'b0);
        wwrite(8'hFB, 16'hBBBB, 1'b0);
        wwrite(8'hFC, 16'hCCCC, 1'b0);
        chk_head("pending3", 1'b1, 4'hA, 16'hAAAA, 8'd0);
        set_idle();
        rst = 1'b1;
        cycle();
        chk_head("rst_pending", 1'b0, 4'h0, 16'h0000, 8'd0);
        chk("rst_pending cpu_rst", 32'(cpu_rst), 32'd1);
        set_idle();
        address = 8'hFA; #1; chk("keep FA", 32'(dataR), 32'h0000AAAA);
        address = 8'hFB; #1; chk("keep FB", 32'(dataR), 32'h0000BBBB);
        address = 8'hFC; #1; chk("keep FC", 32'(dataR), 32'h0000CCCC);
        address = 8'h09; #1; chk("keep 09", 32'(dataR), 32'h0000000A);

        // Random traffic checked against the model every cycle.
        for (int n = 0; n < 2000; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            ld_we     = 1'($urandom);
            ld_addr   = 8'($urandom);
            ld_data   = 16'($urandom);
            ld_done   = ($urandom_range(0, 15) == 0);
            ce        = 1'($urandom);
            we        = 1'($urandom);
            address   = (($urandom % 2) == 0) ? {4'hF, 4'($urandom)} : 8'($urandom);
            dataW     = 16'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            cycle();
            check_model($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
